// File: rtl/y_div8.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, 8 steps per division.
// Results are registered and held until the next completion or reset.
module y_div8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;       // dividend shifts out MSB-first, quotient bits shift in
    logic [7:0] divisor_q, divisor_d;
    logic [7:0] rem_q, rem_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] q_q, q_d;
    logic [7:0] r_q, r_d;
    logic       dbz_q, dbz_d;

    logic [8:0] shifted;
    logic [8:0] diff;
    logic       borrow;
    logic [7:0] rem_step;
    logic [7:0] quo_step;
    logic       capture;

    // The partial remainder stays below the divisor, so bit 8 of the difference is the borrow.
    always_comb begin
        shifted  = {rem_q, dvd_q[7]};
        diff     = shifted - {1'b0, divisor_q};
        borrow   = diff[8];
        rem_step = borrow ? shifted[7:0] : diff[7:0];
        quo_step = {dvd_q[6:0], ~borrow};
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        r_d       = r_q;
        dbz_d     = dbz_q;
        capture   = 1'b0;

        case (state_q)
            StIdle: begin
                capture = start;
            end
            StRun: begin
                dvd_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    q_d     = quo_step;
                    r_d     = rem_step;
                    dbz_d   = (divisor_q == 8'd0);
                    state_d = StDone;
                end
            end
            StDone: begin
                capture = start;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            dvd_d     = a;
            divisor_d = b;
            rem_d     = 8'd0;
            cnt_d     = 3'd0;
            state_d   = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dvd_q     <= 8'd0;
            divisor_q <= 8'd0;
            rem_q     <= 8'd0;
            cnt_q     <= 3'd0;
            q_q       <= 8'd0;
            r_q       <= 8'd0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dbz_q     <= dbz_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_y_div8.sv
// Directed and exhaustive checks for y_div8; a bank of sixteen copies shares the full operand sweep.
module tb_y_div8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [7:0] q, r;
    logic       busy, done, dbz;

    logic       sw_start = 1'b0;
    logic [7:0] sw_b = 8'd0;
    logic [7:0] sw_a    [16];
    logic [7:0] sw_q    [16];
    logic [7:0] sw_r    [16];
    logic       sw_busy [16];
    logic       sw_done [16];
    logic       sw_dbz  [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_div8 u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dbz  (dbz)
    );

    for (genvar g = 0; g < 16; g++) begin : g_sweep
        y_div8 u_sw (
            .clk  (clk),
            .rst_n(rst_n),
            .start(sw_start),
            .a    (sw_a[g]),
            .b    (sw_b),
            .q    (sw_q[g]),
            .r    (sw_r[g]),
            .busy (sw_busy[g]),
            .done (sw_done[g]),
            .dbz  (sw_dbz[g])
        );
    end

    // Launch one division from idle; lat is the number of edges after capture until done shows.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({q, r, busy, done, dbz} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     q, r, busy, done, dbz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_op(8'd100, 8'd7, lat, bcnt);
        checks++;
        if (lat !== 8 || bcnt !== 8) begin
            errors++;
            $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d, want 8 8", lat, bcnt);
        end
        checks++;
        if ({q, r, dbz} !== {8'd14, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL div_100_7: got q=%0d r=%0d dbz=%b, want 14 2 0", q, r, dbz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got done=%b, want 0", done);
        end
        run_op(8'd255, 8'd1, lat, bcnt);
        checks++;
        if ({q, r, dbz} !== {8'd255, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL div_255_1: got q=%0d r=%0d dbz=%b, want 255 0 0", q, r, dbz);
        end
        run_op(8'd5, 8'd9, lat, bcnt);
        checks++;
        if ({q, r, dbz} !== {8'd0, 8'd5, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL div_5_9: got q=%0d r=%0d dbz=%b lat=%0d, want 0 5 0 8",
                     q, r, dbz, lat);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        run_op(8'd200, 8'd0, lat, bcnt);
        checks++;
        if (lat !== 8 || bcnt !== 8) begin
            errors++;
            $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d, want 8 8", lat, bcnt);
        end
        checks++;
        if ({q, r, dbz} !== {8'hFF, 8'd200, 1'b1}) begin
            errors++;
            $display("FAIL div_200_0: got q=%0d r=%0d dbz=%b, want 255 200 1", q, r, dbz);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, bcnt;
        @(negedge clk);
        a = 8'd50;
        b = 8'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd9;
        b = 8'd3;
        n1 = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                n1 = i;
                break;
            end
        end
        checks++;
        if (n1 !== 9 || bcnt !== 8) begin
            errors++;
            $display("FAIL b2b_first_timing: got done_at=%0d busy_cycles=%0d, want 9 8", n1, bcnt);
        end
        checks++;
        if ({q, r, dbz} !== {8'd8, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first_result: got q=%0d r=%0d dbz=%b, want 8 2 0", q, r, dbz);
        end
        @(posedge clk);
        #1 start = 1'b0;
        n2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                n2 = i;
                break;
            end
        end
        checks++;
        if (n2 !== 9) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles between dones, want 9", n2);
        end
        checks++;
        if ({q, r, dbz} !== {8'd3, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second_result: got q=%0d r=%0d dbz=%b, want 3 0 0", q, r, dbz);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, seen;
        @(negedge clk);
        a = 8'd77;
        b = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({q, r, busy, done, dbz} !== 19'd0) begin
            errors++;
            $display("FAIL abort_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     q, r, busy, done, dbz);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles after abort, want 0", seen);
        end
        run_op(8'd77, 8'd5, lat, bcnt);
        checks++;
        if ({q, r, dbz} !== {8'd15, 8'd2, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL div_77_5_fresh: got q=%0d r=%0d dbz=%b lat=%0d, want 15 2 0 8",
                     q, r, dbz, lat);
        end
    endtask

    task automatic test_operand_hold();
        int n;
        @(negedge clk);
        a = 8'd60;
        b = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
        end
        checks++;
        if ({q, r, dbz} !== {8'd15, 8'd0, 1'b0} || n !== 9) begin
            errors++;
            $display("FAIL div_60_4_hold: got q=%0d r=%0d dbz=%b done_at=%0d, want 15 0 0 9",
                     q, r, dbz, n);
        end
        repeat (3) begin
            @(negedge clk);
            a = 8'd1;
            b = 8'd1;
        end
        checks++;
        if ({q, r, dbz, busy, done} !== {8'd15, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL result_hold_idle: got q=%0d r=%0d dbz=%b busy=%b done=%b, want 15 0 0 0 0",
                     q, r, dbz, busy, done);
        end
    endtask

    // Sixteen instances in lockstep, start held high so every division is back-to-back.
    task automatic test_sweep();
        int n;
        logic [7:0] av, eq, er;
        logic       ed;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            for (int bv = 0; bv < 256; bv++) begin
                for (int g = 0; g < 16; g++) sw_a[g] = 8'(g * 16 + k);
                sw_b = 8'(bv);
                sw_start = 1'b1;
                n = -1;
                for (int i = 1; i <= 12; i++) begin
                    @(negedge clk);
                    if (sw_done[0]) begin
                        n = i;
                        break;
                    end
                end
                checks++;
                if (n !== 9) begin
                    errors++;
                    $display("FAIL sweep_latency: k=%0d b=%0d got done_at=%0d, want 9", k, bv, n);
                end
                for (int g = 0; g < 16; g++) begin
                    av = 8'(g * 16 + k);
                    if (bv == 0) begin
                        eq = 8'hFF;
                        er = av;
                        ed = 1'b1;
                    end else begin
                        eq = 8'(int'(av) / bv);
                        er = 8'(int'(av) % bv);
                        ed = 1'b0;
                    end
                    checks++;
                    if ({sw_done[g], sw_q[g], sw_r[g], sw_dbz[g]} !== {1'b1, eq, er, ed}) begin
                        errors++;
                        $display("FAIL sweep_result: a=%0d b=%0d got done=%b q=%0d r=%0d dbz=%b, want 1 %0d %0d %b",
                                 av, bv, sw_done[g], sw_q[g], sw_r[g], sw_dbz[g], eq, er, ed);
                    end
                end
            end
        end
        sw_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int g = 0; g < 16; g++) sw_a[g] = 8'd0;
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_operand_hold();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
